// File: rtl/multi_tick_generator.sv
// multi_tick_generator: N_CH programmable tick / square-wave channels derived from the 100 MHz clock
module multi_tick_generator #(
  parameter int N_CH = 4,
  parameter int CNT_W = 28,
  parameter int DEFAULT_DIV = 100_000_000,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic              clk_100MHz_i,
  input  logic              reset_n_i,
  input  logic [N_CH-1:0]   en_i,
  input  logic [N_CH-1:0]   mode_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_div_i,
  input  logic              sync_i,
  output logic [N_CH-1:0]   tick_o,
  output logic [N_CH-1:0]   wave_o,
  output logic              err_o
);
  logic wr_ok;
  assign wr_ok = wr_div_i >= CNT_W'(2) && {1'b0, wr_ch_i} < (CH_W + 1)'(N_CH);
  // flag a rejected divisor write for exactly one cycle
  always_ff @(posedge clk_100MHz_i or negedge reset_n_i)
    if (!reset_n_i) err_o <= 1'b0;
    else err_o <= wr_en_i && !wr_ok;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, div;
    logic tick, wave, hit;
    assign hit = wr_en_i && wr_ok && wr_ch_i == CH_W'(c);
    assign tick_o[c] = tick;
    assign wave_o[c] = wave;
    // per-channel counter: sync/write restart, enable gates counting, terminal count ticks and drops the wave
    always_ff @(posedge clk_100MHz_i or negedge reset_n_i)
      if (!reset_n_i) begin
        cnt  <= '0;
        div  <= CNT_W'(DEFAULT_DIV);
        tick <= 1'b0;
        wave <= 1'b0;
      end else if (sync_i || hit) begin
        cnt  <= '0;
        tick <= 1'b0;
        wave <= 1'b0;
        if (hit) div <= wr_div_i;
      end else if (!en_i[c]) begin
        tick <= 1'b0;
      end else if (cnt == div - CNT_W'(1)) begin
        cnt  <= '0;
        tick <= 1'b1;
        wave <= 1'b0;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (cnt == (div >> 1) - CNT_W'(1)) wave <= mode_i[c];
      end
  end
endmodule
